// File: rtl/uart_tx_if.sv
// AXI Stream byte channel shared by the UART transmitter and its producer.
interface axis_interface (
    input logic clk
);
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport Source (
        input  clk,
        output tdata,
        output tvalid,
        input  tready
    );

    modport Sink (
        input  clk,
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: AXI Stream byte sink serialised as 8N1 (or 8N2), LSB first, idle high.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic           rst_n,
    axis_interface.Sink    stream,
    output logic           txd,
    output logic           busy
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    logic parity_r;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t        state_r;
    logic [2:0]    bit_cnt_r;
    logic [CW-1:0] cnt_r;
    logic [7:0]    shift_r;
    logic          txd_r;
    logic          tready_r;
    logic          busy_r;
    logic          accept_s;

    // tready_r is only ever high in IDLE or the very last stop-bit cycle.
    assign accept_s      = stream.tvalid && tready_r;
    assign txd           = txd_r;
    assign busy          = busy_r;
    assign stream.tready = tready_r;

    // Frame sequencer with registered txd/tready/busy.
    always_ff @(posedge stream.clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            cnt_r     <= '0;
            shift_r   <= 8'h00;
            txd_r     <= 1'b1;
            tready_r  <= 1'b0;
            busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else if (accept_s) begin
            state_r   <= START;
            bit_cnt_r <= 3'd0;
            cnt_r     <= '0;
            shift_r   <= stream.tdata;
            txd_r     <= 1'b0;
            tready_r  <= 1'b0;
            busy_r    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r  <= even_parity(stream.tdata);
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    txd_r    <= 1'b1;
                    tready_r <= 1'b1;
                    busy_r   <= 1'b0;
                end
                START: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= DATA;
                        txd_r   <= shift_r[0];
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            state_r   <= PARITY;
                            txd_r     <= parity_r;
`else
                            state_r   <= STOP;
                            txd_r     <= 1'b1;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= STOP;
                        txd_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
`endif
                STOP: begin
                    txd_r <= 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        if (bit_cnt_r == STOP_LAST) begin
                            // No new byte offered in the last stop cycle: fall back to idle.
                            state_r   <= IDLE;
                            bit_cnt_r <= 3'd0;
                            busy_r    <= 1'b0;
                            tready_r  <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == CNT_PRE && bit_cnt_r == STOP_LAST) begin
                            tready_r <= 1'b1;
                        end else begin
                            tready_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= 3'd0;
                    cnt_r     <= '0;
                    txd_r     <= 1'b1;
                    tready_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: accepts bytes on an AXI Stream sink and serialises them onto an asynchronous TX line.
- Frame format: 8N1 by default, LSB first, idle-high.
- Transmit-side counterpart of the UART RX peripheral. Sits between an AXI Stream producer (FIFO or core) and the device TX pin.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (115200 bps at 100 MHz); legal range >= 2.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2; any other value is an elaboration error.

Ports:
- stream.clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stream  axis_interface.Sink  -  byte input. Uses tdata [7:0] (in), tvalid (in), tready (out).
- txd  output  1  serial TX line; idle high.
- busy  output  1  high while a frame is being shifted out.

Behaviour:
- Reset is asynchronous assertion, synchronous deassertion handled upstream. Values while rst_n=0:
  - txd=1, stream.tready=0, busy=0
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0
- Reset mid-frame: txd returns high immediately and the partial frame is dropped. No byte is replayed after reset.
- All outputs are registered.
- States and transitions:
  - IDLE: txd=1, tready=1, busy=0. On tvalid&&tready, latch tdata into the shift register and go to START next cycle.
  - START: txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
  - DATA: txd=shift[0], each bit held CLKS_PER_BIT cycles. Shift right after each bit. After bit index 7, go to PARITY (if enabled) or STOP.
  - PARITY: optional feature only; one bit period.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- tready timing:
  - Also asserted during the final clock cycle of the last stop bit.
  - A handshake in that cycle latches the next byte and enters START on the following cycle. Back-to-back frames therefore have zero idle gap: each frame is exactly (10 + (STOP_BITS-1)) * CLKS_PER_BIT cycles, plus CLKS_PER_BIT if parity is enabled.
  - tready is 0 in all other cycles of START/DATA/PARITY/STOP.
  - tdata is sampled only on the handshake cycle; changes to tdata at any other time have no effect.
- Latency: handshake at cycle N gives the txd falling edge (start bit) at cycle N+1.
- busy=1 from the cycle after the handshake through the last stop-bit cycle. It stays 1 across back-to-back frames.
- Cycle counter: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Wraps to 0 at each bit boundary. No off-by-one: every bit is exactly CLKS_PER_BIT cycles.
- If tvalid drops without a handshake, nothing is sent and txd stays high.
- tvalid high during reset: ignored; tready=0 until the first cycle after rst_n deasserts.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after data bit 7. txd = ^byte (even parity), held CLKS_PER_BIT cycles. Frame length grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; frame goes DATA -> STOP directly.

Test Plan:
- Reset: rst_n=0 with tvalid=1 -> txd=1, tready=0, busy=0. First handshake occurs on the first cycle after release.
- Single byte, CLKS_PER_BIT=4, tdata=0x55: handshake at cycle N -> txd low at N+1. Expected pattern 0,1,0,1,0,1,0,1,0,1, each level held exactly 4 cycles; then txd=1, tready=1.
- Back-to-back 0xA5 then 0x3C with tvalid held high -> second start bit begins at exactly N+1+40. No extra idle cycles. busy never drops between frames. A bench UART RX decodes both bytes correctly.
- Backpressure: present byte 0xFF mid-frame -> tready stays 0 until the last stop cycle. The byte is transmitted exactly once. Changing tdata while tready=0 does not alter the sent value.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x00 -> txd=1 within the same cycle (async). After release, module is IDLE and sends the next byte correctly.
- STOP_BITS=2, UART_TX_PARITY_EN defined, tdata=0x07 -> parity bit=1, two stop bits, frame length 12*CLKS_PER_BIT.
